// File: rtl/interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_controller
// Description : Fixed-priority interrupt controller with edge-latched pending
//               bits, enable mask and a non-nesting ack/EOI handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module interrupt_controller #(
    parameter int          N_IRQ         = 8,
    parameter int          ID_W          = 3,
    parameter logic [15:0] VECTOR_BASE   = 16'h0010,
    parameter logic [15:0] VECTOR_STRIDE = 16'h0004
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             en_we,
    input  logic [N_IRQ-1:0] en_wdata,
    input  logic             int_ack,
    input  logic             int_eoi,
    output logic             int_req,
    output logic [ID_W-1:0]  int_id,
    output logic [15:0]      int_vector,
    output logic             in_service,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] int_en
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_SVC  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [N_IRQ-1:0] r_irq_q;
    logic [N_IRQ-1:0] r_pending;
    logic [N_IRQ-1:0] r_en;
    logic             r_int_req;
    logic             r_in_service;
    logic [ID_W-1:0]  r_int_id;
    logic [15:0]      r_int_vector;

    logic [N_IRQ-1:0] w_edge;
    logic [N_IRQ-1:0] w_clr;
    logic [N_IRQ-1:0] w_cand;
    logic [ID_W-1:0]  w_winner;
    logic             w_ack_ok;
    logic             w_req_nxt;
    logic             w_svc_nxt;
    logic [ID_W-1:0]  w_id_nxt;
    logic [15:0]      w_vector_nxt;

    assign w_edge   = irq_in & ~r_irq_q;
    assign w_cand   = r_pending & r_en;
    assign w_ack_ok = (r_state == S_REQ) && int_ack;

    // Clear the acknowledged source only; a same-cycle edge re-sets it below.
    always_comb begin
        w_clr = '0;
        if (w_ack_ok) begin
            w_clr[r_int_id] = 1'b1;
        end
    end

    // Descending scan so the lowest set index is the last (winning) write.
    always_comb begin
        w_winner = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_winner = ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_int_req;
        w_svc_nxt   = r_in_service;
        w_id_nxt    = r_int_id;
        case (r_state)
            S_IDLE: begin
                w_req_nxt = 1'b0;
                w_svc_nxt = 1'b0;
                if (|w_cand) begin
                    w_state_nxt = S_REQ;
                    w_req_nxt   = 1'b1;
                    w_id_nxt    = w_winner;
                end
            end
            S_REQ: begin
                if (int_ack) begin
                    w_state_nxt = S_SVC;
                    w_req_nxt   = 1'b0;
                    w_svc_nxt   = 1'b1;
                end
            end
            S_SVC: begin
                if (int_eoi) begin
                    w_state_nxt = S_IDLE;
                    w_svc_nxt   = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_req_nxt   = 1'b0;
                w_svc_nxt   = 1'b0;
            end
        endcase
    end

    assign w_vector_nxt = VECTOR_BASE + (16'(w_id_nxt) * VECTOR_STRIDE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_q      <= '0;
            r_pending    <= '0;
            r_en         <= '0;
            r_int_req    <= 1'b0;
            r_in_service <= 1'b0;
            r_int_id     <= '0;
            r_int_vector <= VECTOR_BASE;
        end else begin
            r_irq_q      <= irq_in;
            r_pending    <= (r_pending & ~w_clr) | w_edge;
            if (en_we) begin
                r_en <= en_wdata;
            end
            r_int_req    <= w_req_nxt;
            r_in_service <= w_svc_nxt;
            r_int_id     <= w_id_nxt;
            r_int_vector <= w_vector_nxt;
        end
    end

    assign int_req    = r_int_req;
    assign in_service = r_in_service;
    assign int_id     = r_int_id;
    assign int_vector = r_int_vector;
    assign pending    = r_pending;
    assign int_en     = r_en;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_interrupt_controller
// Description : Directed self-checking bench for interrupt_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interrupt_controller;

    logic       clk;
    logic       reset;
    logic [7:0] irq_in;
    logic       en_we;
    logic [7:0] en_wdata;
    logic       int_ack;
    logic       int_eoi;
    logic       int_req;
    logic [2:0] int_id;
    logic [15:0] int_vector;
    logic       in_service;
    logic [7:0] pending;
    logic [7:0] int_en;

    int r_pass;
    int r_total;

    interrupt_controller #(
        .N_IRQ(8), .ID_W(3), .VECTOR_BASE(16'h0010), .VECTOR_STRIDE(16'h0004)
    ) dut (
        .clk(clk), .reset(reset), .irq_in(irq_in), .en_we(en_we),
        .en_wdata(en_wdata), .int_ack(int_ack), .int_eoi(int_eoi),
        .int_req(int_req), .int_id(int_id), .int_vector(int_vector),
        .in_service(in_service), .pending(pending), .int_en(int_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        r_total++;
        if (act === exp) begin
            r_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_req(input string tag, input int budget);
        int n = 0;
        while (!int_req && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_req_timeout"}, 32'(int_req), 32'd1);
    endtask

    task automatic ack_pulse();
        int_ack = 1'b1; tick(); int_ack = 1'b0;
    endtask

    task automatic eoi_pulse();
        int_eoi = 1'b1; tick(); int_eoi = 1'b0;
    endtask

    task automatic write_en(input logic [7:0] m);
        en_we = 1'b1; en_wdata = m; tick(); en_we = 1'b0;
    endtask

    initial begin
        int reqs;
        r_pass = 0; r_total = 0;
        reset = 1'b1; irq_in = '0; en_we = 1'b0; en_wdata = '0;
        int_ack = 1'b0; int_eoi = 1'b0;
        @(negedge clk); tick();
        reset = 1'b0;

        // Reset state
        check("rst_req", 32'(int_req), 0);
        check("rst_svc", 32'(in_service), 0);
        check("rst_id", 32'(int_id), 0);
        check("rst_vec", 32'(int_vector), 32'h10);
        check("rst_pend", 32'(pending), 0);
        check("rst_en", 32'(int_en), 0);

        write_en(8'hFF);
        check("en_ff", 32'(int_en), 32'hFF);

        // Single source, 2-cycle latency
        irq_in = 8'h08; tick();
        check("s_pend", 32'(pending), 32'h08);
        check("s_req_c1", 32'(int_req), 0);
        tick();
        check("s_req_c2", 32'(int_req), 1);
        check("s_id", 32'(int_id), 3);
        check("s_vec", 32'(int_vector), 32'h1C);
        irq_in = 8'h00;
        ack_pulse();
        check("s_ack_req", 32'(int_req), 0);
        check("s_ack_svc", 32'(in_service), 1);
        check("s_ack_pend", 32'(pending), 0);
        check("s_ack_id", 32'(int_id), 3);
        eoi_pulse();
        check("s_eoi_svc", 32'(in_service), 0);
        check("s_eoi_req", 32'(int_req), 0);

        // Priority: 2 before 5
        irq_in = 8'h24; tick();
        check("p_pend", 32'(pending), 32'h24);
        tick(); irq_in = 8'h00;
        check("p_req1", 32'(int_req), 1);
        check("p_id1", 32'(int_id), 2);
        check("p_vec1", 32'(int_vector), 32'h18);
        ack_pulse();
        check("p_pend2", 32'(pending), 32'h20);
        eoi_pulse();
        check("p_idle_gap", 32'(int_req), 0);
        tick();
        check("p_req2", 32'(int_req), 1);
        check("p_id2", 32'(int_id), 5);
        check("p_vec2", 32'(int_vector), 32'h24);
        ack_pulse(); eoi_pulse();

        // Masking
        write_en(8'h00);
        irq_in = 8'h40; tick(); irq_in = 8'h00; tick(); tick();
        check("m_noreq", 32'(int_req), 0);
        check("m_pend", 32'(pending), 32'h40);
        write_en(8'h40);
        check("m_en", 32'(int_en), 32'h40);
        check("m_req_c1", 32'(int_req), 0);
        tick();
        check("m_req_c2", 32'(int_req), 1);
        check("m_id", 32'(int_id), 6);
        ack_pulse(); eoi_pulse();
        write_en(8'hFF);

        // Level hold: exactly one request
        irq_in = 8'h02;
        wait_req("l1", 4);
        check("l_id", 32'(int_id), 1);
        ack_pulse(); eoi_pulse();
        reqs = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (int_req) reqs++;
        end
        check("l_no_retrig", 32'(reqs), 0);
        check("l_pend", 32'(pending), 0);
        irq_in = 8'h00; tick();
        // Fresh edge during SVC
        irq_in = 8'h02; tick(); tick();
        check("l_req2", 32'(int_req), 1);
        ack_pulse();
        irq_in = 8'h00; tick();
        irq_in = 8'h02; tick();
        check("l_svc_pend", 32'(pending), 32'h02);
        check("l_svc_noreq", 32'(int_req), 0);
        irq_in = 8'h00;
        eoi_pulse();
        check("l_gap", 32'(int_req), 0);
        tick();
        check("l_req3", 32'(int_req), 1);
        check("l_id3", 32'(int_id), 1);
        ack_pulse(); eoi_pulse();

        // Collision: edge on bit 4 with ack of id 4
        irq_in = 8'h10; tick(); tick();
        check("c_id", 32'(int_id), 4);
        irq_in = 8'h00; tick();
        check("c_req_hold", 32'(int_req), 1);
        irq_in = 8'h10;
        ack_pulse();
        irq_in = 8'h00;
        check("c_svc", 32'(in_service), 1);
        check("c_pend_kept", 32'(pending), 32'h10);
        eoi_pulse();
        check("c_idle", 32'(int_req), 0);
        ack_pulse();                     // stray ack in IDLE
        check("c_stray_ack_req", 32'(int_req), 1);
        check("c_stray_ack_pend", 32'(pending), 32'h10);
        eoi_pulse();                     // stray eoi in REQ
        check("c_stray_eoi_req", 32'(int_req), 1);
        check("c_stray_eoi_svc", 32'(in_service), 0);
        check("c_stray_eoi_id", 32'(int_id), 4);
        ack_pulse();
        check("c_final_pend", 32'(pending), 0);
        check("c_final_svc", 32'(in_service), 1);

        // Reset while in service
        irq_in = 8'h01; tick();
        reset = 1'b1; tick(); reset = 1'b0; irq_in = 8'h00;
        check("r_svc", 32'(in_service), 0);
        check("r_req", 32'(int_req), 0);
        check("r_id", 32'(int_id), 0);
        check("r_vec", 32'(int_vector), 32'h10);
        check("r_pend", 32'(pending), 0);
        check("r_en", 32'(int_en), 0);
        tick();
        check("r_stay_idle", 32'(int_req), 0);

        $display("%0d/%0d checks passed", r_pass, r_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
